// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request/ready bus transaction per memory op, with lane strobes and load extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and report bus_err.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  off_q, size_q;
    logic        uns_q;
    logic [31:0] count;
    logic        req, trap, timeout_hit;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c, lane, ext;

    assign req = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
    assign trap = (mem_size == 2'b01 && addr[0]) || (mem_size[1] && addr[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = wdata;
        case (mem_size)
            2'b00: begin
                wstrb_c = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << {addr[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the latched offset/size so late input changes cannot corrupt the result.
    assign lane = bus_rdata >> {off_q, 3'b000};
    always_comb begin
        ext = bus_rdata;
        case (size_q)
            2'b00:   ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ext = bus_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (count == 32'(TIMEOUT - 1));
    assign bus_req     = (state == REQ);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: if (req) begin
                stall     = 1'b1;
                state_nxt = trap ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ready || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdata     <= '0;
            bus_err   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            count     <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (req) begin
                        bus_we    <= mem_write;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wstrb <= mem_write ? wstrb_c : 4'b0000;
                        bus_wdata <= wdata_c;
                        off_q     <= addr[1:0];
                        size_q    <= mem_size;
                        uns_q     <= mem_unsigned;
                        if (trap) begin
                            bus_err <= 1'b1;
                            rdata   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        if (!bus_we) rdata <= ext;
                    end else if (timeout_hit) begin
                        rdata   <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                DONE:    bus_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4); build with or without MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic        stall, bus_err, bus_req, bus_we, bus_ready;
    logic [3:0]  bus_wstrb;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Results of the last op, as seen in its DONE cycle.
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_strb;
    logic        o_we, o_err, o_sawreq;
    int          o_stalls;

    // waits<0 means the slave never answers.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                          input int waits);
        int n, rq;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        addr = a; wdata = wd; bus_ready = 1'b0; bus_rdata = rword;
        o_addr = '0; o_wdata = '0; o_strb = '0; o_we = 1'b0; o_sawreq = 1'b0;
        n = 0; rq = 0;
        #1;
        while (stall && n < 40) begin
            n++;
            if (bus_req) begin
                if (rq == 0) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_strb = bus_wstrb; o_we = bus_we;
                    o_sawreq = 1'b1;
                end else begin
                    chk("hold_addr", bus_addr, o_addr);
                    chk("hold_ctl", {27'b0, bus_we, bus_wstrb}, {27'b0, o_we, o_strb});
                end
                bus_ready = (waits >= 0) && (rq >= waits);
                rq++;
            end
            @(negedge clk);
            bus_ready = 1'b0;
            #1;
        end
        if (n >= 40) chk("stall_bound", 32'(n), 32'd0);
        o_stalls = n;
        o_rdata  = rdata;
        o_err    = bus_err;
        chk("done_req", {31'b0, bus_req}, 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        #1;
        chk("err_clear", {31'b0, bus_err}, 32'd0);
        chk("idle_stall", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
        addr = '0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_err", {31'b0, bus_err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_ctl", {27'b0, bus_we, bus_wstrb}, 32'd0);

        // LW zero-wait
        run_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_addr", o_addr, 32'h100);
        chk("lw_stalls", 32'(o_stalls), 32'd2);
        chk("lw_rdata", o_rdata, 32'hDEADBEEF);
        chk("lw_we", {31'b0, o_we}, 32'd0);
        chk("lw_err", {31'b0, o_err}, 32'd0);

        run_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80000000, 0);
        chk("lb_rdata", o_rdata, 32'hFFFFFF80);
        run_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80000000, 0);
        chk("lbu_rdata", o_rdata, 32'h00000080);
        run_op(1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h80000000, 0);
        chk("lhu_rdata", o_rdata, 32'h00008000);
        run_op(1, 0, 2'b00, 1, 32'h101, 32'h0, 32'h12345678, 0);
        chk("lbu1_rdata", o_rdata, 32'h00000056);
        run_op(1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h1234F678, 0);
        chk("lh0_rdata", o_rdata, 32'hFFFFF678);

        // Stores leave rdata at the last load value
        run_op(0, 1, 2'b00, 0, 32'h201, 32'h000000AB, 32'h55555555, 0);
        chk("sb_strb", {28'b0, o_strb}, 32'b0010);
        chk("sb_wdata", o_wdata, 32'hABABABAB);
        chk("sb_we", {31'b0, o_we}, 32'd1);
        chk("sb_addr", o_addr, 32'h200);
        chk("sb_rdata", o_rdata, 32'hFFFFF678);
        run_op(0, 1, 2'b01, 0, 32'h202, 32'h00001234, 32'h0, 0);
        chk("sh_strb", {28'b0, o_strb}, 32'b1100);
        chk("sh_wdata", o_wdata, 32'h12341234);
        run_op(1, 1, 2'b10, 0, 32'h300, 32'hCAFEF00D, 32'h0, 0);
        chk("both_we", {31'b0, o_we}, 32'd1);
        chk("sw_strb", {28'b0, o_strb}, 32'b1111);
        chk("sw_wdata", o_wdata, 32'hCAFEF00D);

        // Three wait states
        run_op(1, 0, 2'b10, 0, 32'h140, 32'h0, 32'h0BADF00D, 3);
        chk("wait_stalls", 32'(o_stalls), 32'd5);
        chk("wait_rdata", o_rdata, 32'h0BADF00D);
        chk("wait_addr", o_addr, 32'h140);

        // Never ready: timeout after TIMEOUT REQ cycles
        run_op(1, 0, 2'b10, 0, 32'h180, 32'h0, 32'h11111111, -1);
        chk("to_err", {31'b0, o_err}, 32'd1);
        chk("to_rdata", o_rdata, 32'd0);
        chk("to_stalls", 32'(o_stalls), 32'd5);

        // Reset while in REQ
        @(negedge clk);
        mem_read = 1'b1; mem_size = 2'b10; addr = 32'h400;
        @(negedge clk);
        #1;
        chk("mid_req", {31'b0, bus_req}, 32'd1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_req", {31'b0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        run_op(1, 0, 2'b10, 0, 32'h500, 32'h0, 32'h76543210, 0);
        chk("post_rst_rdata", o_rdata, 32'h76543210);
        chk("post_rst_addr", o_addr, 32'h500);

        // Misaligned word load
        run_op(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'hA5A5A5A5, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, o_sawreq}, 32'd0);
        chk("mis_err", {31'b0, o_err}, 32'd1);
        chk("mis_rdata", o_rdata, 32'd0);
        chk("mis_stalls", 32'(o_stalls), 32'd1);
`else
        chk("mis_req", {31'b0, o_sawreq}, 32'd1);
        chk("mis_addr", o_addr, 32'h100);
        chk("mis_rdata", o_rdata, 32'hA5A5A5A5);
        chk("mis_err", {31'b0, o_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
